// File: rtl/qci_bsm_tx.sv
// qci_bsm_tx: Alice-side BSM sender; FIFO-buffered results stamped with arrival time and coherence deadline.
// Define QCI_TX_SEQNUM_EN to add an 8-bit tx_seq numbering every message leaving LOAD.
module qci_bsm_tx #(
   parameter int FIFO_DEPTH   = 16,
   parameter int TIME_WIDTH   = 64,
   parameter int LINK_LATENCY = 1000,
   parameter int T2_WINDOW    = 50000
) (
   input  logic                          clk_1g,
   input  logic                          rst_n,
   input  logic                          bsm_valid,
   input  logic [1:0]                    bsm_result,
   input  logic [TIME_WIDTH-1:0]         bsm_time,
   input  logic                          tx_ready,
   output logic                          tx_valid,
   output logic [1:0]                    tx_bell,
   output logic [TIME_WIDTH-1:0]         tx_arrival_time,
   output logic [TIME_WIDTH-1:0]         tx_deadline,
   output logic                          ovf_drop,
   output logic                          stale_drop,
   output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
   output logic [15:0]                   sent_count,
   output logic [15:0]                   ovf_count,
`ifdef QCI_TX_SEQNUM_EN
   output logic [7:0]                    tx_seq,
`endif
   output logic [15:0]                   stale_count
);
   localparam int AW = $clog2(FIFO_DEPTH);
   typedef enum logic [1:0] {IDLE, LOAD, SEND} state_t;
   state_t state, state_nx;
   logic [1:0] mem_bell [FIFO_DEPTH];
   logic [TIME_WIDTH-1:0] mem_time [FIFO_DEPTH];
   logic [AW-1:0] wr_ptr, rd_ptr;
   logic [1:0] hold_bell;
   logic [TIME_WIDTH-1:0] current_time, launch_t, hold_time, arr, dl;
   logic full, push, pop, stale, accept;
   assign full   = fifo_count == (AW+1)'(FIFO_DEPTH);
   assign push   = bsm_valid && !full;
   assign pop    = state == IDLE && fifo_count != '0;
   assign arr    = launch_t + TIME_WIDTH'(LINK_LATENCY);
   assign dl     = hold_time + TIME_WIDTH'(T2_WINDOW);
   assign stale  = arr >= dl;
   assign accept = tx_valid && tx_ready;
   always_comb begin
      state_nx = state == IDLE ? (pop ? LOAD : IDLE) :
                 state == LOAD ? (stale ? IDLE : SEND) :
                 (accept ? IDLE : SEND);
   end
   always_ff @(posedge clk_1g or negedge rst_n)
      if (!rst_n) state <= IDLE;
      else state <= state_nx;
   // Storage is not reset; pointer/count reset is what discards the contents.
   always_ff @(posedge clk_1g)
      if (push) begin
         mem_bell[wr_ptr] <= bsm_result;
         mem_time[wr_ptr] <= bsm_time;
      end
   always_ff @(posedge clk_1g or negedge rst_n)
      if (!rst_n) begin
         current_time    <= '0;
         wr_ptr          <= '0;
         rd_ptr          <= '0;
         fifo_count      <= '0;
         hold_bell       <= '0;
         hold_time       <= '0;
         launch_t        <= '0;
         tx_valid        <= 1'b0;
         tx_bell         <= '0;
         tx_arrival_time <= '0;
         tx_deadline     <= '0;
         ovf_drop        <= 1'b0;
         stale_drop      <= 1'b0;
         sent_count      <= '0;
         ovf_count       <= '0;
         stale_count     <= '0;
      end else begin
         current_time <= current_time + TIME_WIDTH'(1);
         fifo_count   <= fifo_count + (AW+1)'(push) - (AW+1)'(pop);
         ovf_drop     <= bsm_valid && full;
         stale_drop   <= state == LOAD && stale;
         if (push) wr_ptr <= wr_ptr + AW'(1);
         if (bsm_valid && full && ovf_count != 16'hFFFF) ovf_count <= ovf_count + 16'd1;
         if (pop) begin
            rd_ptr    <= rd_ptr + AW'(1);
            hold_bell <= mem_bell[rd_ptr];
            hold_time <= mem_time[rd_ptr];
            launch_t  <= current_time + TIME_WIDTH'(1);
         end
         if (state == LOAD && stale && stale_count != 16'hFFFF) stale_count <= stale_count + 16'd1;
         if (state == LOAD && !stale) begin
            tx_valid        <= 1'b1;
            tx_bell         <= hold_bell;
            tx_arrival_time <= arr;
            tx_deadline     <= dl;
         end
         if (accept) begin
            tx_valid <= 1'b0;
            if (sent_count != 16'hFFFF) sent_count <= sent_count + 16'd1;
         end
      end
`ifdef QCI_TX_SEQNUM_EN
   logic [7:0] seq_ctr;
   always_ff @(posedge clk_1g or negedge rst_n)
      if (!rst_n) begin
         seq_ctr <= '0;
         tx_seq  <= '0;
      end else if (state == LOAD) begin
         seq_ctr <= seq_ctr + 8'd1;
         if (!stale) tx_seq <= seq_ctr;
      end
`endif
endmodule

// File: tb/tb_qci_bsm_tx.sv
// tb_qci_bsm_tx: directed self-checking bench for qci_bsm_tx (default parameters).
module tb_qci_bsm_tx;
   logic clk_1g = 1'b0, rst_n = 1'b0, bsm_valid = 1'b0, tx_ready = 1'b0;
   logic [1:0] bsm_result = '0;
   logic [63:0] bsm_time = '0;
   logic tx_valid, ovf_drop, stale_drop;
   logic [1:0] tx_bell;
   logic [63:0] tx_arrival_time, tx_deadline;
   logic [4:0] fifo_count;
   logic [15:0] sent_count, ovf_count, stale_count;
`ifdef QCI_TX_SEQNUM_EN
   logic [7:0] tx_seq;
`endif
   logic [63:0] now, t0;
   int checks = 0, failures = 0;

   qci_bsm_tx dut (
      .clk_1g(clk_1g), .rst_n(rst_n), .bsm_valid(bsm_valid), .bsm_result(bsm_result),
      .bsm_time(bsm_time), .tx_ready(tx_ready), .tx_valid(tx_valid), .tx_bell(tx_bell),
      .tx_arrival_time(tx_arrival_time), .tx_deadline(tx_deadline), .ovf_drop(ovf_drop),
      .stale_drop(stale_drop), .fifo_count(fifo_count), .sent_count(sent_count),
      .ovf_count(ovf_count),
`ifdef QCI_TX_SEQNUM_EN
      .tx_seq(tx_seq),
`endif
      .stale_count(stale_count));

   always #5 clk_1g = ~clk_1g;
   // Reference clock of the bench: mirrors the free-running time base from reset.
   always @(posedge clk_1g or negedge rst_n) now <= !rst_n ? 64'd0 : now + 64'd1;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic wait_tx(input string tag);
      for (int n = 0; n < 10 && tx_valid !== 1'b1; n++) @(negedge clk_1g);
      chk(tag, tx_valid, 1);
   endtask

   task automatic put(input logic [1:0] r, input logic [63:0] bt, output logic [63:0] t);
      t = now;
      bsm_valid = 1'b1; bsm_result = r; bsm_time = bt;
      @(negedge clk_1g);
      bsm_valid = 1'b0;
   endtask

   task automatic do_reset;
      rst_n = 1'b0; bsm_valid = 1'b0; tx_ready = 1'b0;
      repeat (3) @(negedge clk_1g);
      rst_n = 1'b1;
   endtask

   initial begin
      do_reset();
      chk("rst_valid", tx_valid, 0);
      chk("rst_fifo", fifo_count, 0);
      chk("rst_sent", sent_count, 0);
      chk("rst_ovf", ovf_count, 0);
      chk("rst_stale", stale_count, 0);
      // single BSM written at current_time=10
      tx_ready = 1'b1;
      while (now != 64'd10) @(negedge clk_1g);
      put(2'b10, 64'd8, t0);
      chk("t1_fifo1", fifo_count, 1);
      @(negedge clk_1g);
      chk("t1_fifo0", fifo_count, 0);
      chk("t1_lat", tx_valid, 0);
      @(negedge clk_1g);
      chk("t1_valid", tx_valid, 1);
      chk("t1_bell", tx_bell, 2);
      chk("t1_arr", tx_arrival_time, 1012);
      chk("t1_dl", tx_deadline, 50008);
      @(negedge clk_1g);
      chk("t1_done", tx_valid, 0);
      chk("t1_sent", sent_count, 1);
      chk("t1_fifo", fifo_count, 0);
      // backpressure
      tx_ready = 1'b0;
      repeat (2) @(negedge clk_1g);
      put(2'b01, 64'd100, t0);
      @(negedge clk_1g);
      wait_tx("t2_valid");
      chk("t2_dl", tx_deadline, 50100);
      for (int i = 0; i < 20; i++) begin
         @(negedge clk_1g);
         chk("t2_hold_valid", tx_valid, 1);
         chk("t2_hold_bell", tx_bell, 1);
         chk("t2_hold_arr", tx_arrival_time, t0 + 64'd1002);
      end
      tx_ready = 1'b1;
      @(negedge clk_1g);
      chk("t2_accept", tx_valid, 0);
      repeat (4) @(negedge clk_1g);
      chk("t2_nodup_valid", tx_valid, 0);
      chk("t2_sent", sent_count, 2);
      // overflow: 18 back-to-back writes, link stalled
      tx_ready = 1'b0;
      t0 = now;
      for (int i = 0; i < 18; i++) begin
         chk("t3_no_ovf", ovf_drop, 0);
         bsm_valid = 1'b1; bsm_result = 2'(i); bsm_time = 64'd1000 + 64'(i);
         @(negedge clk_1g);
      end
      bsm_valid = 1'b0;
      chk("t3_ovf_pulse", ovf_drop, 1);
      chk("t3_ovf_count", ovf_count, 1);
      chk("t3_fifo_full", fifo_count, 16);
      chk("t3_held", tx_valid, 1);
      chk("t3_arr0", tx_arrival_time, t0 + 64'd1002);
      @(negedge clk_1g);
      chk("t3_ovf_once", ovf_drop, 0);
      tx_ready = 1'b1;
      for (int k = 0; k < 17; k++) begin
         wait_tx("t3_drain_valid");
         chk("t3_drain_bell", tx_bell, 64'(k % 4));
         chk("t3_drain_dl", tx_deadline, 64'd51000 + 64'(k));
         @(negedge clk_1g);
      end
      repeat (4) @(negedge clk_1g);
      chk("t3_empty_valid", tx_valid, 0);
      chk("t3_sent", sent_count, 19);
      chk("t3_fifo", fifo_count, 0);
      chk("t3_ovf_keep", ovf_count, 1);
      // stale at the exact boundary arr == dl (deadline wraps modulo 2^64)
      put(2'b11, now + 64'd1002 - 64'd50000, t0);
      chk("t4_n0", stale_drop, 0);
      @(negedge clk_1g);
      chk("t4_n1", stale_drop, 0);
      @(negedge clk_1g);
      chk("t4_pulse", stale_drop, 1);
      chk("t4_novalid", tx_valid, 0);
      chk("t4_count", stale_count, 1);
      @(negedge clk_1g);
      chk("t4_once", stale_drop, 0);
      chk("t4_still_novalid", tx_valid, 0);
      // one ns of slack: sent
      put(2'b00, now + 64'd1003 - 64'd50000, t0);
      @(negedge clk_1g);
      wait_tx("t4_edge_valid");
      chk("t4_edge_arr", tx_arrival_time, t0 + 64'd1002);
      chk("t4_edge_dl", tx_deadline, t0 + 64'd1003);
      @(negedge clk_1g);
      chk("t4_edge_sent", sent_count, 20);
      chk("t4_stale_keep", stale_count, 1);
      // reset while in SEND with 5 queued
      tx_ready = 1'b0;
      repeat (2) @(negedge clk_1g);
      for (int i = 0; i < 6; i++) begin
         bsm_valid = 1'b1; bsm_result = 2'(i); bsm_time = 64'd200;
         @(negedge clk_1g);
      end
      bsm_valid = 1'b0;
      wait_tx("t5_valid");
      chk("t5_queued", fifo_count, 5);
      rst_n = 1'b0;
      #1;
      chk("t5_async_valid", tx_valid, 0);
      chk("t5_fifo", fifo_count, 0);
      chk("t5_sent", sent_count, 0);
      chk("t5_ovf", ovf_count, 0);
      chk("t5_stale", stale_count, 0);
      repeat (2) @(negedge clk_1g);
      rst_n = 1'b1;
      tx_ready = 1'b1;
      repeat (3) @(negedge clk_1g);
      chk("t5_idle", tx_valid, 0);
      put(2'b11, 64'd5, t0);
      @(negedge clk_1g);
      wait_tx("t5_new_valid");
      chk("t5_new_bell", tx_bell, 3);
      chk("t5_new_arr", tx_arrival_time, t0 + 64'd1002);
      chk("t5_new_dl", tx_deadline, 50005);
      @(negedge clk_1g);
      chk("t5_new_sent", sent_count, 1);
`ifdef QCI_TX_SEQNUM_EN
      // sequence numbers: send, stale, send
      do_reset();
      chk("t6_rst_seq", tx_seq, 0);
      tx_ready = 1'b1;
      put(2'b01, 64'd100, t0);
      @(negedge clk_1g);
      wait_tx("t6_a_valid");
      chk("t6_a_seq", tx_seq, 0);
      @(negedge clk_1g);
      put(2'b10, now + 64'd1002 - 64'd50000, t0);
      repeat (3) @(negedge clk_1g);
      chk("t6_stale", stale_count, 1);
      put(2'b11, 64'd300, t0);
      @(negedge clk_1g);
      wait_tx("t6_b_valid");
      chk("t6_b_seq", tx_seq, 2);
      @(negedge clk_1g);
`endif
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule

// File: doc/qci_bsm_tx.md
Name: qci_bsm_tx

Overview:
- Alice-side classical sender of the quantum-classical interface.
- Captures Bell-state-measurement (BSM) results from the measurement front-end and buffers them in a FIFO.
- Stamps each message with a launch-based arrival time and a coherence deadline, then emits it over the Instaweb classical link with a valid/ready handshake.
- Messages that can no longer beat the far-end coherence deadline are dropped before launch.

Parameters:
FIFO_DEPTH, 16, BSM FIFO entries; power of 2, minimum 2.
TIME_WIDTH, 64, timestamp width; 1 ns per LSB.
LINK_LATENCY, 1000, classical link flight time in ns.
T2_WINDOW, 50000, coherence window in ns, measured from bsm_time.

Ports:
clk_1g  in  1  1 GHz clock, 1 ns tick.
rst_n  in  1  asynchronous, active-low reset.
bsm_valid  in  1  one-cycle strobe: BSM result available.
bsm_result  in  2  Bell outcome: 00, 01, 10, 11.
bsm_time  in  TIME_WIDTH  absolute time of the measurement.
tx_ready  in  1  link accepts the message.
tx_valid  out  1  message valid.
tx_bell  out  2  Bell outcome sent.
tx_arrival_time  out  TIME_WIDTH  launch time + LINK_LATENCY.
tx_deadline  out  TIME_WIDTH  bsm_time + T2_WINDOW.
ovf_drop  out  1  one-cycle pulse: BSM lost because the FIFO was full.
stale_drop  out  1  one-cycle pulse: message discarded as stale.
fifo_count  out  $clog2(FIFO_DEPTH)+1  current FIFO occupancy.
sent_count  out  16  accepted messages, saturating.
ovf_count  out  16  overflow drops, saturating.
stale_count  out  16  stale drops, saturating.

Behaviour:
- Reset: rst_n is asynchronous, active-low; clock is clk_1g. All outputs, counters and pointers go to 0, state goes to IDLE, FIFO contents are discarded. Assertion mid-operation clears tx_valid immediately, with no handshake completion.
- current_time: internal free-running TIME_WIDTH counter, 0 at reset, +1 per cycle.
- Ingress, every edge:
  - If bsm_valid and fifo_count < FIFO_DEPTH, write {bsm_result, bsm_time}.
  - If bsm_valid and the FIFO is full, pulse ovf_drop and increment ovf_count.
  - Fullness is judged on the registered count before any same-edge pop, so write-while-full plus pop still drops the write.
  - A write and a pop on the same edge leave fifo_count unchanged.
- FSM states: IDLE, LOAD, SEND.
  - IDLE: if the FIFO is not empty, pop the head into holding registers, capture launch_t = current_time + 1, and go to LOAD.
  - LOAD:
    - Compute arr = launch_t + LINK_LATENCY and dl = hold_time + T2_WINDOW.
    - If arr >= dl: pulse stale_drop, increment stale_count, no tx_valid, go to IDLE.
    - Otherwise: drive tx_bell, tx_arrival_time = arr, tx_deadline = dl, set tx_valid = 1, go to SEND.
  - SEND: tx_valid and all tx_* fields are held stable until tx_valid and tx_ready are both high at an edge. On that edge: tx_valid <= 0, increment sent_count, go to IDLE. There is no withdrawal; staleness is checked only in LOAD.
- Latency: a BSM written at edge N into an empty FIFO with the FSM in IDLE gives tx_valid high after edge N+2. Peak throughput is one message per 3 cycles.
- Arithmetic: all time sums are modulo 2^TIME_WIDTH, unsigned compare, no saturation. All counters saturate at 0xFFFF.
- Pointers: wrap modulo FIFO_DEPTH, with an occupancy counter distinguishing full from empty. In LOAD and SEND the popped entry no longer occupies the FIFO.

Optional Feature:
QCI_TX_SEQNUM_EN
- Defined: adds output tx_seq [7:0], valid with tx_valid and reset to 0. An 8-bit sequence counter increments (wrapping) on every LOAD exit, stale or sent, so the receiver detects gaps. tx_seq carries the value assigned to the current message.
- Undefined: the port and counter are absent; behaviour is otherwise identical.

Test Plan:
1. Single BSM: bsm_valid at edge where current_time=10, result=10, bsm_time=8, tx_ready=1 -> tx_bell=10, tx_arrival_time=1012, tx_deadline=50008; sent_count=1; fifo_count back to 0.
2. Backpressure: tx_ready=0 for 20 cycles after tx_valid -> all tx_* fields stable; one accept on tx_ready=1; sent_count=1, no duplicate.
3. Overflow: 18 back-to-back bsm_valid with tx_ready=0 -> 17 retained (1 held + 16 in FIFO); ovf_drop pulses once on the 18th; ovf_count=1; later drain yields 17 messages in order.
4. Stale (T2_WINDOW=2000): bsm_time=0 written at current_time=1500 -> launch+1000 >= 2000 -> stale_drop pulse, stale_count=1, tx_valid never rises.
5. Reset in SEND: rst_n low while tx_valid=1 with 5 queued -> tx_valid=0 immediately, all counts 0; after release a new BSM is sent normally.
6. With QCI_TX_SEQNUM_EN: send, stale, send -> tx_seq values 0 then 2.
